instr_mem_load_rx: RTL and testbench
====================================

// Module: instr_mem_load_rx
// PURPOSE
//  Receiving end of the instruction-load interface (write_instruction_enable/_address/write_instruction).
//  Owns the CPU instruction RAM: commits load writes, tracks program length, and gates the fetch port.
//  Holds the core idle (cpu_run=0, NOP fetch) while a load is in progress; releases it after a quiet holdoff.
// PARAMETERS
//  ADDR_W   10    instruction address width (word addressed)
//  DEPTH    1024  RAM words; DEPTH <= 2**ADDR_W
//  HOLDOFF  4     consecutive enable-low cycles before RUN (>=1)
// PORTS
//  clk                        in   1        system clock, all state on posedge
//  rst                        in   1        asynchronous reset, active-high
//  write_instruction_enable   in   1        load write strobe, sampled each posedge
//  write_instruction_address  in   ADDR_W   load word address
//  write_instruction          in   32       load data word
//  fetch_pc                   in   ADDR_W   core fetch address
//  fetch_instr                out  32       fetched word, 1-cycle latency
//  cpu_run                    out  1        high = program loaded, core may execute
//  prog_len                   out  ADDR_W+1 highest accepted address + 1
//  wr_err                     out  1        sticky: write seen with address >= DEPTH
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, fetch_instr=0, cpu_run=0, prog_len=0, wr_err=0, holdoff cnt=0.
//   RAM contents are NOT cleared by reset; they persist across rst.
//  Write: every posedge with enable=1 and address<DEPTH writes RAM[address]=data; last write wins when
//   enable stays high over several edges. address>=DEPTH: no write, wr_err<=1, prog_len unchanged.
//  prog_len <= max(prog_len, address+1) on each accepted write; never decreases until rst.
//  FSM (registered, one transition per cycle):
//   IDLE    : enable=1 -> LOADING (write committed same edge).
//   LOADING : enable=0 -> SETTLE, cnt<=1.
//   SETTLE  : enable=1 -> LOADING (write committed); else cnt==HOLDOFF -> RUN; else cnt<=cnt+1.
//   RUN     : enable=1 -> LOADING (write committed; cpu_run low from next cycle).
//  cpu_run is a register = (next state == RUN); rises on the edge entering RUN.
//  Fetch: fetch_instr <= (state==RUN) ? RAM[fetch_pc] : 32'h0 (NOP). fetch_pc>=DEPTH reads 0.
//   Same-cycle write and fetch to same address in RUN: write-first (new data returned).
//  Reset mid-load: aborts immediately; words already written stay in RAM; re-load required to RUN.
//  IDLE with enable never asserted: core never released (cpu_run stays 0).
// CONFIGURATION
//  INSTR_READBACK_EN defined: adds ports dbg_addr (in, ADDR_W) and dbg_data (out, 32);
//   dbg_data <= RAM[dbg_addr] every cycle, 1-cycle latency, any state, write-first; reset value 0;
//   dbg_addr>=DEPTH reads 0. Implemented as second read port (true dual-port/duplicated RAM).
//  Not defined: ports absent, RAM single read port; all other behaviour identical.
// TESTING
//  1 rst pulse, no writes, 50 cycles -> cpu_run=0, fetch_instr=0, prog_len=0, wr_err=0 throughout.
//  2 write addr0=0x40008008, addr1=0x40010007, addr2=0x0C110000 (enable high 1 cycle each), then
//    enable low -> cpu_run rises exactly HOLDOFF(4) edges after last write edge; prog_len=3;
//    fetch_pc=0,1,2 -> fetch_instr 0x40008008,0x40010007,0x0C110000 one cycle later.
//  3 enable held high 3 edges on addr5 with data 0x1,0x2,0x3 -> RAM[5]=0x3, prog_len=6.
//  4 in RUN, write addr1=0xDEADBEEF with fetch_pc=1 same edge -> cpu_run=0 next cycle,
//    fetch_instr=0; after holdoff, fetch_pc=1 returns 0xDEADBEEF.
//  5 DEPTH=512, write addr 600 -> wr_err=1 sticky, prog_len unchanged, RAM untouched; clears only on rst.
//  6 rst asserted mid-SETTLE -> cpu_run=0 same time (async); after rst, fetch of previously loaded
//    addr0 with INSTR_READBACK_EN via dbg_addr=0 -> dbg_data=0x40008008 (RAM retained).

Source files
------------

// File: rtl/instr_mem_load_rx.sv
// ----------------------------------------------------------------------------
// instr_mem_load_rx
//
// Receiving end of the instruction-load interface. Owns the CPU instruction
// RAM. It commits load writes, tracks the program length and gates the core
// fetch port. While a load is in progress the core is held idle: cpu_run is
// low and fetches return NOP (zero). Once the write strobe has been quiet for
// HOLDOFF consecutive cycles, the core is released.
//
// Parameters
//   ADDR_W   instruction address width (word addressed)
//   DEPTH    RAM words, DEPTH <= 2**ADDR_W
//   HOLDOFF  consecutive enable-low cycles before RUN (>= 1)
//
// Ports
//   clk                        in   1         system clock, all state on posedge
//   rst                        in   1         asynchronous reset, active-high
//   write_instruction_enable   in   1         load write strobe
//   write_instruction_address  in   ADDR_W    load word address
//   write_instruction          in   32        load data word
//   fetch_pc                   in   ADDR_W    core fetch address
//   fetch_instr                out  32        fetched word, 1-cycle latency
//   cpu_run                    out  1         program loaded, core may execute
//   prog_len                   out  ADDR_W+1  highest accepted address + 1
//   wr_err                     out  1         sticky: write seen with address >= DEPTH
//   dbg_addr                   in   ADDR_W    (INSTR_READBACK_EN) readback address
//   dbg_data                   out  32        (INSTR_READBACK_EN) readback data, 1-cycle latency
//
// Build option
//   INSTR_READBACK_EN : when defined, adds the dbg_addr/dbg_data readback port.
//                       This is a second read port on the RAM. When it is not
//                       defined, the RAM has a single read port.
//
// State table
//   IDLE    | after reset, no load seen yet; core held
//   LOADING | write strobe active; core held
//   SETTLE  | strobe dropped, counting quiet cycles in cnt; core held
//   RUN     | program loaded, core released
//
// RAM contents are deliberately not reset, so a program survives rst.
// ----------------------------------------------------------------------------
module instr_mem_load_rx #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_instruction_enable,
    input  logic [ADDR_W-1:0] write_instruction_address,
    input  logic [31:0]       write_instruction,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              cpu_run,
    output logic [ADDR_W:0]   prog_len,
    output logic              wr_err
`ifdef INSTR_READBACK_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    localparam int CNT_W = $clog2(HOLDOFF + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic              wr_in_range;
    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W:0]   wr_len;
    logic              fetch_in_range;
    logic [IDX_W-1:0]  fetch_idx;

    // Address checks are done one bit wider, so that DEPTH == 2**ADDR_W is representable.
    assign wr_in_range    = ({1'b0, write_instruction_address} < DEPTH_C);
    assign wr_ok          = write_instruction_enable && wr_in_range;
    assign wr_idx         = write_instruction_address[IDX_W-1:0];
    assign wr_len         = {1'b0, write_instruction_address} + (ADDR_W + 1)'(1);
    assign fetch_in_range = ({1'b0, fetch_pc} < DEPTH_C);
    assign fetch_idx      = fetch_pc[IDX_W-1:0];

    // cnt holds the number of quiet edges seen so far. The edge that brings
    // the count to HOLDOFF is the edge that enters RUN. A single write edge
    // followed by HOLDOFF quiet edges therefore releases the core.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (write_instruction_enable) state_nxt = LOADING;
            end
            LOADING: begin
                if (!write_instruction_enable) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (HOLDOFF_C == CNT_ONE) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (write_instruction_enable) begin
                    state_nxt = LOADING;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt_nxt == HOLDOFF_C) state_nxt = RUN;
                end
            end
            RUN: begin
                if (write_instruction_enable) state_nxt = LOADING;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cpu_run <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cpu_run <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_len <= '0;
            wr_err   <= 1'b0;
        end else begin
            if (wr_ok && (wr_len > prog_len)) prog_len <= wr_len;
            if (write_instruction_enable && !wr_in_range) wr_err <= 1'b1;
        end
    end

    // RAM array: no reset, contents persist. Writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_idx] <= write_instruction;
    end

    // Fetch port. Gating is on the current state, and a write to the same word
    // on the same edge is forwarded (write-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_instr <= 32'h0;
        end else if ((state == RUN) && fetch_in_range) begin
            if (wr_ok && (write_instruction_address == fetch_pc))
                fetch_instr <= write_instruction;
            else
                fetch_instr <= mem[fetch_idx];
        end else begin
            fetch_instr <= 32'h0;
        end
    end

`ifdef INSTR_READBACK_EN
    logic             dbg_in_range;
    logic [IDX_W-1:0] dbg_idx;

    assign dbg_in_range = ({1'b0, dbg_addr} < DEPTH_C);
    assign dbg_idx      = dbg_addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_data <= 32'h0;
        end else if (dbg_in_range) begin
            if (wr_ok && (write_instruction_address == dbg_addr))
                dbg_data <= write_instruction;
            else
                dbg_data <= mem[dbg_idx];
        end else begin
            dbg_data <= 32'h0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_load_rx.sv
module tb_instr_mem_load_rx;

    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 512;
    localparam int HOLDOFF = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       fetch_instr;
    logic              cpu_run;
    logic [ADDR_W:0]   prog_len;
    logic              wr_err;
`ifdef INSTR_READBACK_EN
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instr_mem_load_rx #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .write_instruction_enable  (en),
        .write_instruction_address (addr),
        .write_instruction         (data),
        .fetch_pc                  (fetch_pc),
        .fetch_instr               (fetch_instr),
        .cpu_run                   (cpu_run),
        .prog_len                  (prog_len),
        .wr_err                    (wr_err)
`ifdef INSTR_READBACK_EN
        ,
        .dbg_addr                  (dbg_addr),
        .dbg_data                  (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One posedge, then return at the following negedge where checks/stimulus happen.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (cpu_run !== 1'b0 || fetch_instr !== 32'h0 || prog_len !== 11'd0 || wr_err !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d bad cycles, cpu_run=%b fetch=%h prog_len=%0d wr_err=%b, required all 0",
                     bad, cpu_run, fetch_instr, prog_len, wr_err);
        end
    endtask

    task automatic test_load_run();
        logic [31:0] words [3];
        words[0] = 32'h40008008;
        words[1] = 32'h40010007;
        words[2] = 32'h0C110000;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; addr = ADDR_W'(i); data = words[i];
            step();
        end
        en = 1'b0;
        for (int i = 1; i <= HOLDOFF; i++) begin
            step();
            n_tests++;
            if (cpu_run !== (i == HOLDOFF)) begin
                n_fail++;
                $display("FAIL holdoff_edge%0d: cpu_run=%b required %b", i, cpu_run, (i == HOLDOFF));
            end
        end
        n_tests++;
        if (prog_len !== 11'd3) begin
            n_fail++;
            $display("FAIL prog_len_3: got %0d required 3", prog_len);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_pc = ADDR_W'(i);
            step();
            n_tests++;
            if (fetch_instr !== words[i]) begin
                n_fail++;
                $display("FAIL fetch_%0d: got %h required %h", i, fetch_instr, words[i]);
            end
        end
    endtask

    task automatic test_held_enable();
        en = 1'b1; addr = 10'd5;
        data = 32'h1; step();
        n_tests++;
        if (cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cpu_run: got %b required 0", cpu_run);
        end
        data = 32'h2; step();
        data = 32'h3; step();
        en = 1'b0;
        n_tests++;
        if (prog_len !== 11'd6) begin
            n_fail++;
            $display("FAIL held_prog_len: got %0d required 6", prog_len);
        end
        for (int i = 0; i < HOLDOFF; i++) step();
        fetch_pc = 10'd5;
        step();
        n_tests++;
        if (cpu_run !== 1'b1 || fetch_instr !== 32'h3) begin
            n_fail++;
            $display("FAIL held_last_wins: cpu_run=%b fetch=%h required 1 / 00000003", cpu_run, fetch_instr);
        end
    endtask

    task automatic test_write_in_run();
        fetch_pc = 10'd1;
        en = 1'b1; addr = 10'd1; data = 32'hDEADBEEF;
        step();
        en = 1'b0;
        n_tests++;
        if (cpu_run !== 1'b0 || fetch_instr !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL run_write_first: cpu_run=%b fetch=%h required 0 / deadbeef", cpu_run, fetch_instr);
        end
        step();
        n_tests++;
        if (fetch_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL nop_while_loading: got %h required 00000000", fetch_instr);
        end
        for (int i = 1; i < HOLDOFF; i++) step();
        n_tests++;
        if (cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun: cpu_run=%b required 1", cpu_run);
        end
        step();
        n_tests++;
        if (fetch_instr !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL refetch_1: got %h required deadbeef", fetch_instr);
        end
    endtask

    task automatic test_out_of_range();
        // 600 aliases 88 if the address were truncated to 9 bits
        en = 1'b1; addr = 10'd88; data = 32'h00000088; step();
        n_tests++;
        if (wr_err !== 1'b0 || prog_len !== 11'd89) begin
            n_fail++;
            $display("FAIL pre_err: wr_err=%b prog_len=%0d required 0 / 89", wr_err, prog_len);
        end
        addr = 10'd600; data = 32'hBAD00BAD; step();
        n_tests++;
        if (wr_err !== 1'b1 || prog_len !== 11'd89) begin
            n_fail++;
            $display("FAIL oor_write: wr_err=%b prog_len=%0d required 1 / 89", wr_err, prog_len);
        end
        addr = 10'd511; data = 32'h5115115A; step();
        en = 1'b0;
        n_tests++;
        if (wr_err !== 1'b1 || prog_len !== 11'd512) begin
            n_fail++;
            $display("FAIL boundary_511: wr_err=%b prog_len=%0d required 1 / 512", wr_err, prog_len);
        end
        for (int i = 0; i < HOLDOFF; i++) step();
        fetch_pc = 10'd88; step();
        n_tests++;
        if (fetch_instr !== 32'h00000088) begin
            n_fail++;
            $display("FAIL ram_untouched: got %h required 00000088", fetch_instr);
        end
        fetch_pc = 10'd511; step();
        n_tests++;
        if (fetch_instr !== 32'h5115115A) begin
            n_fail++;
            $display("FAIL fetch_511: got %h required 5115115a", fetch_instr);
        end
        fetch_pc = 10'd600; step();
        n_tests++;
        if (fetch_instr !== 32'h0 || wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_oor: fetch=%h wr_err=%b required 00000000 / 1", fetch_instr, wr_err);
        end
    endtask

    task automatic test_reset_mid_settle();
        en = 1'b1; addr = 10'd3; data = 32'h33333333; step();
        en = 1'b0; step(); step();
        rst = 1'b1;
        #1;
        n_tests++;
        if (cpu_run !== 1'b0 || prog_len !== 11'd0 || wr_err !== 1'b0 || fetch_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: cpu_run=%b prog_len=%0d wr_err=%b fetch=%h required all 0",
                     cpu_run, prog_len, wr_err, fetch_instr);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < HOLDOFF + 2; i++) step();
        n_tests++;
        if (cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rerun_without_load: cpu_run=%b required 0", cpu_run);
        end
`ifdef INSTR_READBACK_EN
        dbg_addr = 10'd0; step();
        n_tests++;
        if (dbg_data !== 32'h40008008) begin
            n_fail++;
            $display("FAIL dbg_retained: got %h required 40008008", dbg_data);
        end
        dbg_addr = 10'd700; step();
        n_tests++;
        if (dbg_data !== 32'h0) begin
            n_fail++;
            $display("FAIL dbg_oor: got %h required 00000000", dbg_data);
        end
`endif
        en = 1'b1; addr = 10'd3; data = 32'h0000C0DE; step();
        en = 1'b0;
        for (int i = 0; i < HOLDOFF; i++) step();
        fetch_pc = 10'd0; step();
        n_tests++;
        if (cpu_run !== 1'b1 || prog_len !== 11'd4 || fetch_instr !== 32'h40008008) begin
            n_fail++;
            $display("FAIL ram_retained: cpu_run=%b prog_len=%0d fetch=%h required 1 / 4 / 40008008",
                     cpu_run, prog_len, fetch_instr);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; addr = '0; data = '0; fetch_pc = '0;
`ifdef INSTR_READBACK_EN
        dbg_addr = '0;
`endif
        @(negedge clk);
        test_reset();
        test_load_run();
        test_held_enable();
        test_write_in_run();
        test_out_of_range();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
